// File: rtl/coherence_bus_ctrl.sv
// Coherence/memory controller between CPUS cores' private I/D caches and one RAM port.
// Round-robin arbitration, snoop broadcast, and cache-to-cache transfer with RAM writeback.
module coherence_bus_ctrl #(
  parameter int CPUS  = 2,
  parameter int WORDS = 2,
  parameter int DW    = 32
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS*DW-1:0]   iaddr,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS*DW-1:0]   iload,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS*DW-1:0]   daddr,
  input  logic [CPUS*DW-1:0]   dstore,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS*DW-1:0]   dload,
  input  logic [CPUS-1:0]      cctrans,
  input  logic [CPUS-1:0]      ccwrite,
  output logic [CPUS-1:0]      ccwait,
  output logic [CPUS-1:0]      ccinv,
  output logic [CPUS*DW-1:0]   ccsnoopaddr,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [DW-1:0]        ramaddr,
  output logic [DW-1:0]        ramstore,
  input  logic [DW-1:0]        ramload,
  input  logic [1:0]           ramstate
);

  localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [2:0] {IDLE, DWB, SNOOP_REQ, SNOOP_RSP, C2C, DREAD, IFETCH} state_t;

  state_t        state;
  logic [IW-1:0] dptr, iptr, req, resp;
  logic [CW-1:0] cnt;

  logic [DW-1:0] iaddr_w  [CPUS];
  logic [DW-1:0] daddr_w  [CPUS];
  logic [DW-1:0] dstore_w [CPUS];

  logic [CPUS-1:0] dreq;
  logic [IW-1:0]   dgrant, igrant, resp_next;
  logic            dfound, ifound, rfound;
  logic            access, snooping;

  assign dreq     = dWEN | dREN | cctrans;
  assign access   = (ramstate == RAM_ACCESS);
  assign snooping = (state == SNOOP_REQ) || (state == SNOOP_RSP);

  genvar gi;
  generate
    for (gi = 0; gi < CPUS; gi++) begin : g_core
      assign iaddr_w[gi]  = iaddr[gi*DW +: DW];
      assign daddr_w[gi]  = daddr[gi*DW +: DW];
      assign dstore_w[gi] = dstore[gi*DW +: DW];
      assign ccsnoopaddr[gi*DW +: DW] = (snooping && req != IW'(gi)) ? daddr_w[req] : '0;
      assign iload[gi*DW +: DW] = (state == IFETCH && req == IW'(gi)) ? ramload : '0;
      assign dload[gi*DW +: DW] = (state == DREAD && req == IW'(gi)) ? ramload :
                                  (state == C2C   && req == IW'(gi)) ? dstore_w[resp] : '0;
    end
  endgenerate

  // Scan from the far end so the last hit written is the first requester at/after the pointer.
  always_comb begin
    int dj, ij;
    dgrant = '0;
    igrant = '0;
    dfound = 1'b0;
    ifound = 1'b0;
    for (int i = CPUS - 1; i >= 0; i--) begin
      dj = int'(dptr) + i;
      if (dj >= CPUS) dj = dj - CPUS;
      ij = int'(iptr) + i;
      if (ij >= CPUS) ij = ij - CPUS;
      if (dreq[IW'(dj)]) begin
        dgrant = IW'(dj);
        dfound = 1'b1;
      end
      if (iREN[IW'(ij)]) begin
        igrant = IW'(ij);
        ifound = 1'b1;
      end
    end
  end

  always_comb begin
    resp_next = '0;
    rfound    = 1'b0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      if (IW'(k) != req && ccwrite[IW'(k)]) begin
        resp_next = IW'(k);
        rfound    = 1'b1;
      end
    end
  end

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
    return (int'(g) == CPUS - 1) ? '0 : g + 1'b1;
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      dptr  <= '0;
      iptr  <= '0;
      req   <= '0;
      resp  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (dfound) begin
            req   <= dgrant;
            dptr  <= next_ptr(dgrant);
            state <= dWEN[dgrant] ? DWB : SNOOP_REQ;
          end else if (ifound) begin
            req   <= igrant;
            iptr  <= next_ptr(igrant);
            state <= IFETCH;
          end
        end
        DWB, C2C, DREAD: begin
          if (access) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        SNOOP_REQ: state <= SNOOP_RSP;
        SNOOP_RSP: begin
          resp <= resp_next;
          cnt  <= '0;
          if (!dREN[req])  state <= IDLE;
          else if (rfound) state <= C2C;
          else             state <= DREAD;
        end
        IFETCH: if (access) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    iwait    = '1;
    dwait    = '1;
    ccwait   = '0;
    ccinv    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      DWB: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr_w[req];
        ramstore = dstore_w[req];
        if (access) dwait[req] = 1'b0;
      end
      SNOOP_REQ, SNOOP_RSP: begin
        ccwait      = ~({{(CPUS-1){1'b0}}, 1'b1} << req);
        ccinv       = ccwrite[req] ? ccwait : '0;
        if (state == SNOOP_RSP && !dREN[req]) dwait[req] = 1'b0;
      end
      C2C: begin
        ccwait[resp] = 1'b1;
        ramWEN       = 1'b1;
        ramaddr      = daddr_w[resp];
        ramstore     = dstore_w[resp];
        if (access) begin
          dwait[req]  = 1'b0;
          dwait[resp] = 1'b0;
        end
      end
      DREAD: begin
        ramREN  = 1'b1;
        ramaddr = daddr_w[req];
        if (access) dwait[req] = 1'b0;
      end
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr_w[req];
        if (access) iwait[req] = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Randomized bench for coherence_bus_ctrl against a transaction-level reference model.
module tb_coherence_bus_ctrl;
  localparam int CPUS = 4;
  localparam int WORDS = 2;
  localparam int DW = 32;
  localparam int NCYC = 3000;
  localparam logic [1:0] RS_ACCESS = 2'd2;

  localparam int K_NONE = 0;
  localparam int K_WB   = 1;
  localparam int K_SNP  = 2;
  localparam int K_C2C  = 3;
  localparam int K_RD   = 4;
  localparam int K_IF   = 5;

  logic                CLK = 1'b0;
  logic                nRST;
  logic [CPUS-1:0]     iREN, iwait, dREN, dWEN, dwait, cctrans, ccwrite, ccwait, ccinv;
  logic [CPUS*DW-1:0]  iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
  logic                ramREN, ramWEN;
  logic [DW-1:0]       ramaddr, ramstore, ramload;
  logic [1:0]          ramstate;

  always #5 CLK = ~CLK;

  coherence_bus_ctrl #(.CPUS(CPUS), .WORDS(WORDS), .DW(DW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: current transaction kind, snoop phase, beats done, who asked / who answers.
  int kind, phase, beats, mreq, mresp, dp, ip;

  logic [CPUS-1:0]    e_iwait, e_dwait, e_ccwait, e_ccinv;
  logic               e_ramREN, e_ramWEN;
  logic [DW-1:0]      e_ramaddr, e_ramstore;
  logic [CPUS*DW-1:0] e_iload, e_dload, e_snoop;

  task automatic check(input string tag, input logic [CPUS*DW-1:0] got, input logic [CPUS*DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input logic [CPUS*DW-1:0] v, input int k);
    return v[k*DW +: DW];
  endfunction

  function automatic int first_at(input logic [CPUS-1:0] r, input int ptr);
    for (int i = 0; i < CPUS; i++)
      if (r[(ptr + i) % CPUS]) return (ptr + i) % CPUS;
    return -1;
  endfunction

  function automatic string kind_name(input int k);
    case (k)
      K_WB:    return "writeback";
      K_SNP:   return "upgrade";
      K_C2C:   return "c2c";
      K_RD:    return "dread";
      K_IF:    return "ifetch";
      default: return "none";
    endcase
  endfunction

  task automatic model_reset();
    kind = K_NONE; phase = 0; beats = 0; mreq = 0; mresp = 0; dp = 0; ip = 0;
  endtask

  task automatic model_expect();
    bit acc;
    acc = (ramstate == RS_ACCESS);
    e_iwait = '1; e_dwait = '1; e_ccwait = '0; e_ccinv = '0;
    e_ramREN = 1'b0; e_ramWEN = 1'b0; e_ramaddr = '0; e_ramstore = '0;
    e_iload = '0; e_dload = '0; e_snoop = '0;
    case (kind)
      K_WB: begin
        e_ramWEN = 1'b1;
        e_ramaddr = word(daddr, mreq);
        e_ramstore = word(dstore, mreq);
        if (acc) e_dwait[mreq] = 1'b0;
      end
      K_SNP: begin
        for (int k = 0; k < CPUS; k++) begin
          if (k != mreq) begin
            e_ccwait[k] = 1'b1;
            e_ccinv[k] = ccwrite[mreq];
            e_snoop[k*DW +: DW] = word(daddr, mreq);
          end
        end
        if (phase == 1 && !dREN[mreq]) e_dwait[mreq] = 1'b0;
      end
      K_C2C: begin
        e_ccwait[mresp] = 1'b1;
        e_dload[mreq*DW +: DW] = word(dstore, mresp);
        e_ramWEN = 1'b1;
        e_ramaddr = word(daddr, mresp);
        e_ramstore = word(dstore, mresp);
        if (acc) begin
          e_dwait[mreq] = 1'b0;
          e_dwait[mresp] = 1'b0;
        end
      end
      K_RD: begin
        e_ramREN = 1'b1;
        e_ramaddr = word(daddr, mreq);
        e_dload[mreq*DW +: DW] = ramload;
        if (acc) e_dwait[mreq] = 1'b0;
      end
      K_IF: begin
        e_ramREN = 1'b1;
        e_ramaddr = word(iaddr, mreq);
        e_iload[mreq*DW +: DW] = ramload;
        if (acc) e_iwait[mreq] = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic finish_txn();
    $display("txn %s core %0d resp %0d @%0t", kind_name(kind), mreq, mresp, $time);
    kind = K_NONE;
    beats = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit acc;
    int g, found;
    acc = (ramstate == RS_ACCESS);
    case (kind)
      K_NONE: begin
        beats = 0;
        g = first_at(dWEN | dREN | cctrans, dp);
        if (g >= 0) begin
          mreq = g;
          dp = (g + 1) % CPUS;
          kind = dWEN[g] ? K_WB : K_SNP;
          phase = 0;
        end else begin
          g = first_at(iREN, ip);
          if (g >= 0) begin
            mreq = g;
            ip = (g + 1) % CPUS;
            kind = K_IF;
          end
        end
      end
      K_WB, K_C2C, K_RD: begin
        if (acc) begin
          beats++;
          if (beats == WORDS) finish_txn();
        end
      end
      K_SNP: begin
        if (phase == 0) begin
          phase = 1;
        end else begin
          found = -1;
          for (int k = CPUS - 1; k >= 0; k--)
            if (k != mreq && ccwrite[k]) found = k;
          mresp = (found >= 0) ? found : 0;
          beats = 0;
          if (!dREN[mreq]) finish_txn();
          else kind = (found >= 0) ? K_C2C : K_RD;
        end
      end
      K_IF: if (acc) finish_txn();
      default: kind = K_NONE;
    endcase
  endtask

  task automatic drive_random();
    int r;
    for (int k = 0; k < CPUS; k++) begin
      iREN[k]    = ($urandom_range(0, 1) == 0);
      dWEN[k]    = ($urandom_range(0, 7) == 0);
      dREN[k]    = ($urandom_range(0, 3) == 0);
      cctrans[k] = ($urandom_range(0, 3) == 0);
      ccwrite[k] = ($urandom_range(0, 1) == 0);
      iaddr[k*DW +: DW]  = $urandom;
      daddr[k*DW +: DW]  = $urandom;
      dstore[k*DW +: DW] = $urandom;
    end
    ramload = $urandom;
    r = $urandom_range(0, 9);
    ramstate = (r < 5) ? 2'd2 : (r < 7) ? 2'd1 : (r < 8) ? 2'd0 : 2'd3;
  endtask

  task automatic compare_all();
    model_expect();
    check("iwait", iwait, e_iwait);
    check("dwait", dwait, e_dwait);
    check("ccwait", ccwait, e_ccwait);
    check("ccinv", ccinv, e_ccinv);
    check("ccsnoopaddr", ccsnoopaddr, e_snoop);
    check("iload", iload, e_iload);
    check("dload", dload, e_dload);
    check("ramREN", ramREN, e_ramREN);
    check("ramWEN", ramWEN, e_ramWEN);
    check("ramaddr", ramaddr, e_ramaddr);
    check("ramstore", ramstore, e_ramstore);
  endtask

  initial begin
    nRST = 1'b0;
    drive_random();
    model_reset();
    @(negedge CLK);
    #1;
    compare_all();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge CLK);
      drive_random();
      // Occasional reset lands mostly mid-transaction and must drop everything back to idle.
      if ($urandom_range(0, 149) == 0) begin
        nRST = 1'b0;
        model_reset();
      end else begin
        nRST = 1'b1;
      end
      #1;
      compare_all();
      @(posedge CLK);
      if (nRST) model_step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
- N-core memory/coherence controller between CPUS private I/D caches and the single-ported RAM.
- Arbitrates instruction fetches, data writebacks and coherent data misses with independent round-robin pointers.
- Broadcasts snoops to all non-requesting caches and performs cache-to-cache transfer with simultaneous RAM writeback on a dirty hit.
- Transfers are WORDS blocks of DW-bit words.

Parameters:
- CPUS, 2, number of cores (2..8)
- WORDS, 2, words per cache block (power of 2, >=1)
- DW, 32, word/address width

Ports:
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- iREN  in  CPUS  instruction read request per core
- iaddr  in  CPUS*DW  instruction address per core
- iwait  out  CPUS  per-core instruction stall
- iload  out  CPUS*DW  instruction data per core
- dREN  in  CPUS  data read (miss fill) request
- dWEN  in  CPUS  data write (writeback / flush) request
- daddr  in  CPUS*DW  data address per core
- dstore  in  CPUS*DW  data write / snoop-response data per core
- dwait  out  CPUS  per-core data stall
- dload  out  CPUS*DW  data fill per core
- cctrans  in  CPUS  core requests coherent transaction
- ccwrite  in  CPUS  requester: write intent; snooped cache: dirty hit
- ccwait  out  CPUS  snoop in progress, cache must service ccsnoopaddr
- ccinv  out  CPUS  invalidate snooped block
- ccsnoopaddr  out  CPUS*DW  snoop address per core
- ramREN, ramWEN  out  1 each  RAM strobes
- ramaddr, ramstore  out  DW each  RAM address / write data
- ramload  in  DW  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Reset (async): state IDLE, iwait='1, dwait='1, all other outputs 0; dptr=ipptr=0, word counter 0, latched req/resp indices 0.
- Outputs are combinational from state plus latched indices; defaults each cycle are iwait='1, dwait='1, everything else 0.
- States: IDLE, DWB, SNOOP_REQ, SNOOP_RSP, C2C, DREAD, IFETCH.
- Arbitration in IDLE:
  - A data request is dWEN|dREN|cctrans; data beats instruction.
  - Grant goes to the first requesting core at or after dptr (modulo CPUS); dptr becomes grant+1 on grant.
  - Instruction grants use iptr identically.
  - Grant index is latched as req; no dead ARBITRATE cycle.
  - dWEN[req] -> DWB; else (cctrans|dREN)[req] -> SNOOP_REQ; else iREN -> IFETCH.
- DWB: ramWEN=1, ramaddr=daddr[req], ramstore=dstore[req].
  - On ACCESS: dwait[req]=0 and word counter increments.
  - After WORDS ACCESS beats -> IDLE.
- SNOOP_REQ (1 cycle): for every k!=req, ccwait[k]=1, ccsnoopaddr[k]=daddr[req], ccinv[k]=ccwrite[req]. Then -> SNOOP_RSP.
- SNOOP_RSP (1 cycle): same drive as SNOOP_REQ.
  - resp = lowest k!=req with ccwrite[k]; latched.
  - dREN[req]=0 (upgrade only) -> IDLE, dwait[req]=0 this cycle.
  - Else dirty hit -> C2C; else -> DREAD.
- C2C: ccwait[resp] stays 1; dload[req]=dstore[resp]; ramWEN=1, ramaddr=daddr[resp], ramstore=dstore[resp].
  - On ACCESS: dwait[req]=0, dwait[resp]=0, counter++.
  - After WORDS beats -> IDLE.
- DREAD: ramREN=1, ramaddr=daddr[req], dload[req]=ramload.
  - On ACCESS: dwait[req]=0, counter++.
  - After WORDS beats -> IDLE.
- IFETCH: ramREN=1, ramaddr=iaddr[req], iload[req]=ramload.
  - On ACCESS: iwait[req]=0 -> IDLE (single word).
- RAM handshake rules:
  - BUSY/FREE: hold state and all outputs.
  - ERROR: hold and retry; counter does not advance.
- Counter is log2(WORDS) bits (1 bit when WORDS=1), cleared on every entry to IDLE.
- A request withdrawn mid-transaction does not abort it; the block completes.
- Reset mid-transaction: immediate IDLE, waits high, counters and pointers cleared.
- Only one wait bit per class is ever low in a cycle, except C2C, which releases two dwait bits.

Test Plan:
- CPUS=4, iREN=4'b1111, RAM ACCESS every 2nd cycle -> iwait released in core order 0,1,2,3,0, each after one ACCESS; iload[k]=ramload.
- Core 2 dWEN daddr=0x100, WORDS=2, simultaneous iREN[0] -> two RAM writes to 0x100/0x104 from dstore[2] before any ifetch; dwait[2] low on both ACCESS cycles.
- Core 1 cctrans+dREN+ccwrite=0, daddr=0x200, no dirty sharer -> ccwait=4'b1101 for 2 cycles with ccinv=0 -> DREAD, dload[1]=ramload.
- Core 0 cctrans+dREN+ccwrite=1, core 3 ccwrite=1 with dstore=0xDEADBEEF -> ccinv=4'b1110, C2C: dload[0]=0xDEADBEEF, ramstore=0xDEADBEEF, dwait[0] and dwait[3] low together.
- Upgrade: cctrans[1]=1, ccwrite[1]=1, dREN=0 -> snoop with ccinv to others, dwait[1] low in SNOOP_RSP, no RAM access.
- ramstate=ERROR for 3 cycles during DREAD, then nRST asserted mid-DWB -> no counter advance during ERROR; after reset, state IDLE and all waits 1.
